instr_encode: RTL
=================

INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 Parameter DEPTH, default 2, output buffer entries; SHALL be a power of two and at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  field set presented.
REQ-005 in_ready  output  1  field set accepted this cycle when in_valid is also high.
REQ-006 op  input  7  opcode.
REQ-007 rd, rs1, rs2  input  5 each  register indices.
REQ-008 funct3  input  3; funct7  input  7.
REQ-009 imm  input  32  signed or upper immediate, as produced by the decoder.
REQ-010 out_valid  output  1  instr is valid.
REQ-011 out_ready  input  1  consumer takes instr this cycle when out_valid is also high.
REQ-012 instr  output  32  encoded RV32I word.
REQ-013 out_err  output  1  qualifies instr; high means the field set was unencodable.
REQ-014 enc_count  output  16  number of accepted field sets.

Function
REQ-015 The encoding type SHALL follow op:
- U: 0110111, 0010111
- J: 1101111
- B: 1100011
- I: 1100111, 0000011, 0010011
- S: 0100011
- R: 0110011
REQ-016 Field placement SHALL be the exact inverse of the RV32I decode.
- Fields unused by a type (for example rs2 for I-type, or funct7 for non-R types) SHALL be ignored.
REQ-017 Immediate range check:
- I and S: imm[31:11] all equal.
- B: imm[0]=0 and imm[31:12] all equal.
- J: imm[0]=0 and imm[31:20] all equal.
- U: imm[11:0]=0.
REQ-018 An unknown op or a failed range check SHALL produce instr=32'h0000_0013 (NOP) with out_err=1; otherwise out_err=0.
REQ-019 A transfer SHALL occur only in a cycle where in_valid and in_ready are both high.
- On transfer, the encoded word and its error flag SHALL be pushed into a DEPTH-entry FIFO.
REQ-020 in_ready SHALL equal "FIFO not full".
- in_ready SHALL NOT depend combinationally on out_ready.
- When full, a same-cycle pop SHALL NOT allow a push in that cycle.
REQ-021 out_valid SHALL equal "FIFO not empty".
- instr and out_err SHALL come from the head entry, registered, with no combinational path from the input fields.
REQ-022 Latency: a word accepted in cycle N into an empty FIFO SHALL have out_valid high in cycle N+1.
REQ-023 A simultaneous push and pop when not full and not empty SHALL leave the occupancy unchanged and preserve order.
REQ-024 instr and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH; the full and empty flags SHALL be unambiguous (extra pointer bit or occupancy counter).
REQ-026 enc_count SHALL increment by 1 per transfer, including errored transfers, and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-027 While rst_n=0 the following SHALL hold, regardless of the clock:
- FIFO empty;
- out_valid=0;
- instr=0;
- out_err=0;
- enc_count=0.
REQ-028 Assertion mid-operation SHALL discard all buffered words.
- After release, the first valid output SHALL be the first word accepted after reset.
REQ-029 in_ready SHALL be 0 during reset and SHALL be 1 from the first clock edge after release.

Structure
REQ-030 Opcode constants, the instrType encoding (U=1, J=2, B=3, I=4, S=5, R=6) and the NOP constant SHALL live in a shared package, riscv_pkg, used by both decode and instr_encode.
REQ-031 Encoding SHALL be one combinational block feeding one sub-module, instr_fifo (width 33: instr plus err; depth DEPTH).

Verification
REQ-032 ADDI x1,x0,5 (op 0010011, rd 1, rs1 0, funct3 0, imm 5) -> instr 0x00500093, out_err 0, out_valid the cycle after accept.
REQ-033 LUI x2 with imm 0x12345000 -> 0x12345137; SUB x3,x1,x2 (funct7 0100000) -> 0x402081B3; JAL x1 with imm 8 -> 0x008000EF.
REQ-034 Error cases, each -> 0x00000013 with out_err 1 and enc_count incremented:
- BEQ with imm -3 (misaligned);
- ADDI with imm 4096 (out of range);
- op 1111111 (unknown).
REQ-035 Backpressure: out_ready=0, offer 3 field sets -> in_ready low after 2 accepts; raise out_ready -> words emerge in order with no loss or duplication.
REQ-036 Reset: assert rst_n=0 with 2 entries buffered -> out_valid 0 and enc_count 0 immediately; after release, a fresh ADDI emerges as the sole output.
REQ-037 enc_count preset via 65535 transfers -> one further transfer gives 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, instruction-format encoding and the canonical NOP.
// Used by both the decoder and the encoder so the two always agree on op -> format.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_U    = 3'd1,
        TYPE_J    = 3'd2,
        TYPE_B    = 3'd3,
        TYPE_I    = 3'd4,
        TYPE_S    = 3'd5,
        TYPE_R    = 3'd6
    } instr_type_e;

    function automatic instr_type_e op_type(input logic [6:0] op);
        instr_type_e t;
        case (op)
            OP_LUI, OP_AUIPC:           t = TYPE_U;
            OP_JAL:                     t = TYPE_J;
            OP_BRANCH:                  t = TYPE_B;
            OP_JALR, OP_LOAD, OP_OPIMM: t = TYPE_I;
            OP_STORE:                   t = TYPE_S;
            OP_OP:                      t = TYPE_R;
            default:                    t = TYPE_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full and empty never alias.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update; a push is refused while full even if a pop happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push && !full) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instr_encode.sv
// RV32I field-set to instruction-word encoder with range checking and a DEPTH-entry
// output buffer; unencodable field sets produce a NOP flagged with out_err.
module instr_encode
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        out_err,
    output logic [15:0] enc_count
);

    instr_type_e type_s;
    logic [31:0] word_s;
    logic        fits_s;
    logic [31:0] enc_word_s;
    logic        enc_err_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic        rdy_en_r;
    logic [15:0] enc_count_r;

    // Field placement (inverse of decode) and immediate range check per format.
    always_comb begin
        type_s = op_type(op);
        word_s = NOP;
        fits_s = 1'b0;
        case (type_s)
            TYPE_U: begin
                fits_s = (imm[11:0] == 12'h000);
                word_s = {imm[31:12], rd, op};
            end
            TYPE_J: begin
                fits_s = !imm[0] && (imm[31:20] == {12{imm[20]}});
                word_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            TYPE_B: begin
                fits_s = !imm[0] && (imm[31:12] == {20{imm[12]}});
                word_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            end
            TYPE_I: begin
                fits_s = (imm[31:11] == {21{imm[11]}});
                word_s = {imm[11:0], rs1, funct3, rd, op};
            end
            TYPE_S: begin
                fits_s = (imm[31:11] == {21{imm[11]}});
                word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            end
            TYPE_R: begin
                fits_s = 1'b1;
                word_s = {funct7, rs2, rs1, funct3, rd, op};
            end
            default: begin
                fits_s = 1'b0;
                word_s = NOP;
            end
        endcase
        if (fits_s) begin
            enc_word_s = word_s;
            enc_err_s  = 1'b0;
        end else begin
            enc_word_s = NOP;
            enc_err_s  = 1'b1;
        end
    end

    assign in_ready  = rdy_en_r && !full_s;
    assign out_valid = !empty_s;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign enc_count = enc_count_r;

    // Input enable (held off until the first edge after reset) and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_r    <= 1'b0;
            enc_count_r <= 16'h0000;
        end else begin
            rdy_en_r <= 1'b1;
            if (push_s) begin
                enc_count_r <= enc_count_r + 16'h0001;
            end
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({enc_err_s, enc_word_s}),
        .rdata ({out_err, instr}),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule
